// File: rtl/fasa_pkg.sv
// Shared definitions for the fetch-loop sequencer: widths, opcodes and the
// sequencer state type.
package fasa_pkg;

  localparam int PC_W      = 10;
  localparam int INSTR_W   = 9;
  localparam int LUT_DEPTH = 16;
  localparam int LUT_AW    = $clog2(LUT_DEPTH);
  localparam int CNT_W     = 16;

  localparam logic [3:0] OP_BRA_ABS = 4'b1110;
  localparam logic [3:0] OP_BRA_REL = 4'b1111;
  localparam logic [3:0] OP_HALT    = 4'b1101;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    RUN,
    BUBBLE,
    HALTED
  } bc_state_t;

  function automatic logic [3:0] opcodeOf(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: 4];
  endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// Bundle of the sequencer's fetch, table-load and PC-control signals.
interface branch_ctrl_if;
  import fasa_pkg::*;

  logic               Go;
  logic [INSTR_W-1:0] Instr;
  logic [PC_W-1:0]    ProgCtr;
  logic               LutWe;
  logic [LUT_AW-1:0]  LutAddr;
  logic [PC_W-1:0]    LutData;
  logic               Start;
  logic               BranchAbsEn;
  logic               BranchRelEn;
  logic [PC_W-1:0]    Target;
  logic               Done;
  logic [CNT_W-1:0]   InstrCount;

  modport master (
    output Go, Instr, ProgCtr, LutWe, LutAddr, LutData,
    input  Start, BranchAbsEn, BranchRelEn, Target, Done, InstrCount
  );

  modport slave (
    input  Go, Instr, ProgCtr, LutWe, LutAddr, LutData,
    output Start, BranchAbsEn, BranchRelEn, Target, Done, InstrCount
  );

endinterface

// File: rtl/branch_ctrl_target_lut.sv
// Branch target table: register file with synchronous write and clear,
// asynchronous read (a same-cycle write is seen only on the next cycle).
module target_lut
  import fasa_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              We,
  input  logic [LUT_AW-1:0] WAddr,
  input  logic [PC_W-1:0]   WData,
  input  logic [LUT_AW-1:0] RAddr,
  output logic [PC_W-1:0]   RData
);

  logic [PC_W-1:0] entries [LUT_DEPTH];

  // NOTE: this table is small flops, not a RAM macro, so clearing every
  // entry on reset is cheap and guarantees branches never see stale targets.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < LUT_DEPTH; i++) entries[i] <= '0;
    end else if (We) begin
      entries[WAddr] <= WData;
    end
  end

  assign RData = entries[RAddr];

endmodule

// File: rtl/branch_ctrl.sv
// Front-end sequencer: decodes branch/halt opcodes from the fetched
// instruction and drives the PC's start, branch-enable and target inputs.
module branch_ctrl
  import fasa_pkg::*;
(
  input  logic         Clk,
  input  logic         Reset,
  branch_ctrl_if.slave bus
);

  bc_state_t         state;
  logic              startReg;
  logic              doneReg;
  logic [CNT_W-1:0]  instrCount;
  logic [3:0]        opcode;
  logic [LUT_AW-1:0] idx;
  logic [PC_W-1:0]   lutRead;
  logic              isAbs;
  logic              isRel;
  logic              isHalt;

  target_lut uLut (
    .Clk   (Clk),
    .Reset (Reset),
    .We    (bus.LutWe),
    .WAddr (bus.LutAddr),
    .WData (bus.LutData),
    .RAddr (idx),
    .RData (lutRead)
  );

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    opcode = opcodeOf(bus.Instr);
    idx    = bus.Instr[LUT_AW-1:0];
    isAbs  = 1'b0;
    isRel  = 1'b0;
    isHalt = 1'b0;
    if (state == RUN) begin
      isAbs  = (opcode == OP_BRA_ABS);
      isRel  = (opcode == OP_BRA_REL);
      isHalt = (opcode == OP_HALT);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      startReg   <= 1'b1;
      doneReg    <= 1'b0;
      instrCount <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Go) begin
            state      <= LAUNCH;
            instrCount <= '0;
          end
        end
        LAUNCH: begin
          state    <= RUN;
          startReg <= 1'b0;
        end
        RUN: begin
          if (instrCount != '1) instrCount <= instrCount + 1'b1;
          if (isAbs || isRel) begin
            state <= BUBBLE;
          end else if (isHalt) begin
            state    <= HALTED;
            startReg <= 1'b1;
            doneReg  <= 1'b1;
          end
        end
        BUBBLE: state <= RUN;
        HALTED: begin
          // Go must drop before another run can begin.
          if (!bus.Go) begin
            state   <= IDLE;
            doneReg <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          startReg <= 1'b1;
          doneReg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Start       = startReg;
  assign bus.Done        = doneReg;
  assign bus.InstrCount  = instrCount;
  assign bus.BranchAbsEn = isAbs;
  assign bus.BranchRelEn = isRel;
  assign bus.Target      = (isAbs || isRel) ? lutRead : '0;

  // The PC value and Instr[4] carry no meaning for this block.
  logic unusedBits;
  assign unusedBits = ^{bus.ProgCtr, bus.Instr[4]};

endmodule
